// File: rtl/rom_loader.sv
// rom_loader: fills the CPU instruction ROM from a checksummed host byte stream
// and holds the CPU in reset until the image verifies.
`default_nettype none

module rom_loader #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [15:0]       instruction,
  output logic              cpu_reset,
  output logic              loading,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_W_HI   = 3'd2,
    S_W_LO   = 3'd3,
    S_CSUM   = 3'd4,
    S_RUN    = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t            state, state_nx;
  logic [15:0]       cnt;
  logic [7:0]        sum;
  logic [7:0]        hi;
  logic [ADDR_W-1:0] wcount;
  logic [15:0]       rom [DEPTH];
  logic              accept;
  logic              restart;
  logic [15:0]       cnt_full;
  logic [31:0]       wcount_inc;

  assign accept       = rx_valid & rx_ready;
  assign restart      = start & ((state == S_RUN) | (state == S_ERROR));
  assign cnt_full     = {cnt[15:8], rx_data};
  assign wcount_inc   = 32'(wcount) + 32'd1;
  assign words_loaded = wcount;

  always_ff @(posedge clk) begin
    if (reset) state <= S_CNT_HI;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rx_ready  = 1'b0;
    loading   = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (state)
      S_CNT_HI: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) state_nx = S_CNT_LO;
      end
      S_CNT_LO: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) begin
          // the decision uses the low byte arriving this cycle
          if (32'(cnt_full) > DEPTH) state_nx = S_ERROR;
          else if (cnt_full == 16'd0) state_nx = S_CSUM;
          else                        state_nx = S_W_HI;
        end
      end
      S_W_HI: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) state_nx = S_W_LO;
      end
      S_W_LO: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) state_nx = (wcount_inc == 32'(cnt)) ? S_CSUM : S_W_HI;
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        loading  = 1'b1;
        if (rx_valid) state_nx = (rx_data == sum) ? S_RUN : S_ERROR;
      end
      S_RUN: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) state_nx = S_CNT_HI;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_nx = S_CNT_HI;
      end
      default: state_nx = S_CNT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      sum    <= '0;
      hi     <= '0;
      wcount <= '0;
    end else if (restart) begin
      cnt    <= '0;
      sum    <= '0;
      wcount <= '0;
    end else if (accept) begin
      case (state)
        S_CNT_HI: begin
          cnt[15:8] <= rx_data;
          sum       <= sum + rx_data;
        end
        S_CNT_LO: begin
          cnt[7:0] <= rx_data;
          sum      <= sum + rx_data;
        end
        S_W_HI: begin
          hi  <= rx_data;
          sum <= sum + rx_data;
        end
        S_W_LO: begin
          wcount <= wcount + 1'b1;
          sum    <= sum + rx_data;
        end
        default: ;
      endcase
    end
  end

  // ROM contents survive reset; only the load pointer is cleared
  always_ff @(posedge clk) begin
    if (!reset && accept && (state == S_W_LO))
      rom[wcount[IDX_W-1:0]] <= {hi, rx_data};
  end

  assign instruction = (32'(pc) < DEPTH) ? rom[pc[IDX_W-1:0]] : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: load outcomes are queued by the stimulus and
// checked by a monitor when done/error rises; ROM and flags are checked directly.
`default_nettype none

module tb_rom_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [ADDR_W-1:0] pc = '0;
  logic [15:0]       instruction;
  logic              cpu_reset, loading, done, error;
  logic [ADDR_W-1:0] words_loaded;

  rom_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pc(pc), .instruction(instruction), .cpu_reset(cpu_reset),
    .loading(loading), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dn;
    logic       er;
    logic [3:0] wl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: each rising edge of done|error is one completed load.
  logic prev_ev = 1'b0;
  always @(negedge clk) begin
    if ((done | error) && !prev_ev) begin
      if (q.size() == 0) begin
        chk("unexpected_outcome", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("outcome_done", 32'(done), 32'(e.dn));
        chk("outcome_error", 32'(error), 32'(e.er));
        chk("outcome_words", 32'(words_loaded), 32'(e.wl));
      end
    end
    prev_ev = done | error;
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n == 10) chk("byte_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_seq(input logic [7:0] s[], input int gap);
    foreach (s[i]) send(s[i], gap);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [15:0] exp);
    pc = a;
    #1;
    chk(name, 32'(instruction), 32'(exp));
  endtask

  logic [7:0] nominal[] = '{8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'h03};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_loading", 32'(loading), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);

    // nominal load
    q.push_back('{dn: 1'b1, er: 1'b0, wl: 4'd2});
    send_seq(nominal, 0);
    chk("nom_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_rx_ready", 32'(rx_ready), 32'd0);
    chk("nom_loading", 32'(loading), 32'd0);
    rd("nom_rom0", 4'd0, 16'h0005);
    rd("nom_rom1", 4'd1, 16'hEC10);
    rd("nom_pc_oob", 4'd5, 16'h0000);

    // bad checksum, then a good retry
    pulse_start();
    chk("start_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_words", 32'(words_loaded), 32'd0);
    q.push_back('{dn: 1'b0, er: 1'b1, wl: 4'd1});
    send_seq('{8'h00, 8'h01, 8'h12, 8'h34, 8'h00}, 0);
    chk("badck_error", 32'(error), 32'd1);
    chk("badck_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("badck_rx_ready", 32'(rx_ready), 32'd0);
    rd("badck_rom0", 4'd0, 16'h1234);
    pulse_start();
    chk("err_start_error", 32'(error), 32'd0);
    q.push_back('{dn: 1'b1, er: 1'b0, wl: 4'd1});
    send_seq('{8'h00, 8'h01, 8'h12, 8'h34, 8'h47}, 0);
    chk("retry_done", 32'(done), 32'd1);

    // empty image
    pulse_start();
    q.push_back('{dn: 1'b1, er: 1'b0, wl: 4'd0});
    send_seq('{8'h00, 8'h00, 8'h00}, 0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_words", 32'(words_loaded), 32'd0);

    // oversize count rejected right after the count bytes
    pulse_start();
    q.push_back('{dn: 1'b0, er: 1'b1, wl: 4'd0});
    send_seq('{8'h00, 8'h05}, 0);
    chk("over_error", 32'(error), 32'd1);
    chk("over_loading", 32'(loading), 32'd0);
    rd("over_rom0", 4'd0, 16'h1234);

    // count exactly DEPTH fills the whole ROM
    pulse_start();
    q.push_back('{dn: 1'b1, er: 1'b0, wl: 4'd4});
    send_seq('{8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22,
               8'h33, 8'h33, 8'h44, 8'h44, 8'h58}, 0);
    chk("full_done", 32'(done), 32'd1);
    rd("full_rom3", 4'd3, 16'h4444);
    rd("full_rom0", 4'd0, 16'h1111);

    // gaps with junk between bytes
    pulse_start();
    q.push_back('{dn: 1'b1, er: 1'b0, wl: 4'd2});
    send_seq(nominal, 3);
    chk("gap_done", 32'(done), 32'd1);
    rd("gap_rom0", 4'd0, 16'h0005);
    rd("gap_rom1", 4'd1, 16'hEC10);
    rd("gap_rom2", 4'd2, 16'h3333);

    // reset mid-load keeps written words
    pulse_start();
    send_seq('{8'h00, 8'h02, 8'hAB, 8'hCD, 8'hEC}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_loading", 32'(loading), 32'd1);
    chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    rd("midrst_rom0", 4'd0, 16'hABCD);
    q.push_back('{dn: 1'b1, er: 1'b0, wl: 4'd2});
    send_seq(nominal, 0);
    chk("reload_done", 32'(done), 32'd1);
    rd("reload_rom0", 4'd0, 16'h0005);

    // start inside a load is ignored
    pulse_start();
    q.push_back('{dn: 1'b1, er: 1'b0, wl: 4'd2});
    send_seq('{8'h00, 8'h02, 8'h00, 8'h05}, 0);
    pulse_start();
    chk("ldstart_loading", 32'(loading), 32'd1);
    chk("ldstart_words", 32'(words_loaded), 32'd1);
    chk("ldstart_rx_ready", 32'(rx_ready), 32'd1);
    send_seq('{8'hEC, 8'h10, 8'h03}, 0);
    chk("ldstart_done", 32'(done), 32'd1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
